coin_acceptor: RTL and testbench

Front-end stage directly upstream of the vending machine FSM. Converts the two raw, bouncy, asynchronous coin-sensor lines (1-peso and 5-peso slots) into clean, single-cycle `P1`/`P5` pulses on `clk`. Coin events are buffered in a small FIFO and spaced by a guaranteed idle gap. Same-cycle dual-slot events (jam) are flagged and discarded, so the vending FSM never sees `P1` and `P5` together.

---
 rtl/coin_acceptor.sv | 167 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end for the vending FSM. Turns the two bouncy, asynchronous coin
//   sensor lines into clean single-cycle P1/P5 pulses, queued in a small FIFO
//   and separated by a guaranteed idle gap. Simultaneous 1-peso and 5-peso
//   events are reported as a jam and discarded.
//
// Parameters
//   DEB_CYCLES  stable synced cycles before a debounced level changes (1..255)
//   GAP         idle cycles enforced after each output pulse (0..15)
//   QDEPTH      coin FIFO depth, power of 2 (2..16)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   coin1_raw  asynchronous 1-peso sensor, high while a coin passes
//   coin5_raw  asynchronous 5-peso sensor
//   P1, P5     one-cycle pulse per accepted 1-peso / 5-peso coin
//   jam        one-cycle pulse when both channels produce an event together
//   ovf        one-cycle pulse when an event is dropped on a full FIFO
//   busy       FIFO non-empty or output FSM not idle
//   pending    FIFO occupancy after the current edge
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP        = 2,
  parameter int QDEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         coin1_raw,
  input  logic                         coin5_raw,
  output logic                         P1,
  output logic                         P5,
  output logic                         jam,
  output logic                         ovf,
  output logic                         busy,
  output logic [$clog2(QDEPTH+1)-1:0]  pending
);

  localparam int              CW       = $clog2(QDEPTH + 1);
  localparam int              PW       = $clog2(QDEPTH);
  localparam logic [7:0]      DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0]   FULL_CNT = CW'(QDEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} state_t;

  // Channel vectors: bit 0 = 1-peso, bit 1 = 5-peso.
  logic [1:0]    sync1, sync2;
  logic [1:0]    deb, deb_d;
  logic [7:0]    deb_cnt [2];
  logic [1:0]    ev;

  logic          push, pop, full, push_ok;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_mem [QDEPTH];   // 0 = 1-peso, 1 = 5-peso

  state_t        state;
  logic [3:0]    gap_cnt;

  // Two-flop synchronizers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {coin5_raw, coin1_raw};
      sync2 <= sync1;
    end
  end

  // Debounce: deb toggles once the synced level has disagreed with it for
  // DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= ~deb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edges of the debounced levels are coin events. Exactly one channel
  // is a valid coin; both together is a jam and nothing is queued.
  assign ev      = deb & ~deb_d;
  assign push    = ev[0] ^ ev[1];
  assign full    = (count == FULL_CNT);
  assign pop     = (state == ST_IDLE) && (count != '0);
  assign push_ok = push && (!full || pop);

  // NOTE: FIFO storage is deliberately left out of reset; the pointers and
  // count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= ev[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      jam    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      jam   <= ev[0] & ev[1];
      ovf   <= push & full & ~pop;
    end
  end

  // Output FSM. The pulse is registered on the pop edge, so P1/P5 are high
  // exactly during the EMIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      P1      <= 1'b0;
      P5      <= 1'b0;
    end else begin
      // NOTE: the default-low assignment is overridden later in the same block;
      // with non-blocking assignments the last one wins, giving a clean pulse.
      P1 <= 1'b0;
      P5 <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            P1    <= ~fifo_mem[rd_ptr];
            P5    <=  fifo_mem[rd_ptr];
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LAST;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (count != '0) || (state != ST_IDLE);
  assign pending = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor
//   Drives two instances: the nominal configuration (DEB_CYCLES=4, GAP=2,
//   QDEPTH=4) and a fast-debounce, long-gap configuration (1, 6, 4) that can
//   actually fill the FIFO. Each is compared every cycle against a reference
//   model built from coin timestamps, a coin queue and a sample history.
module tb_coin_acceptor;

  localparam int L0_DEB = 4, L0_GAP = 2;
  localparam int L1_DEB = 1, L1_GAP = 6;
  localparam int QD     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin1_raw = 1'b0, coin5_raw = 1'b0;
  logic s_coin1 = 1'b0, s_coin5 = 1'b0;
  logic P1, P5, jam, ovf, busy;
  logic s_P1, s_P5, s_jam, s_ovf, s_busy;
  logic [2:0] pending, s_pending;

  coin_acceptor #(.DEB_CYCLES(L0_DEB), .GAP(L0_GAP), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .coin1_raw(coin1_raw), .coin5_raw(coin5_raw),
    .P1(P1), .P5(P5), .jam(jam), .ovf(ovf), .busy(busy), .pending(pending)
  );

  coin_acceptor #(.DEB_CYCLES(L1_DEB), .GAP(L1_GAP), .QDEPTH(QD)) dut_stress (
    .clk(clk), .rst_n(rst_n), .coin1_raw(s_coin1), .coin5_raw(s_coin5),
    .P1(s_P1), .P5(s_P5), .jam(s_jam), .ovf(s_ovf), .busy(s_busy), .pending(s_pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int          t_edge = 0;
  logic [15:0] h1 [2];          // raw samples, bit 0 = most recent edge
  logic [15:0] h5 [2];
  bit          deb1 [2], deb5 [2], debd1 [2], debd5 [2];
  bit          q0 [$];
  bit          q1 [$];
  int          ready_edge [2];  // first edge at which the next pop may occur
  bit          m_p1 [2], m_p5 [2], m_jam [2], m_ovf [2], m_busy [2];
  int          m_pending [2];

  // Debounced level flips once the last n synced samples all disagree with it.
  // Synced sample seen at edge t is the raw sample of edge t-2.
  function automatic bit settled(input logic [15:0] h, input bit d, input int n);
    for (int i = 1; i <= n; i++) if (h[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input int l, input bit c1, input bit c5, input bit rn);
    bit q [$];
    bit ev1, ev5, pop, head;
    int dcy, gp;
    dcy = (l == 0) ? L0_DEB : L1_DEB;
    gp  = (l == 0) ? L0_GAP : L1_GAP;
    if (l == 0) q = q0; else q = q1;
    if (!rn) begin
      q.delete();
      h1[l] = '0; h5[l] = '0;
      deb1[l] = 0; deb5[l] = 0; debd1[l] = 0; debd5[l] = 0;
      ready_edge[l] = 0;
      m_p1[l] = 0; m_p5[l] = 0; m_jam[l] = 0; m_ovf[l] = 0; m_busy[l] = 0;
      m_pending[l] = 0;
    end else begin
      ev1  = deb1[l] & ~debd1[l];
      ev5  = deb5[l] & ~debd5[l];
      pop  = (q.size() > 0) && (t_edge >= ready_edge[l]);
      head = 1'b0;
      if (pop) begin
        head = q.pop_front();
        ready_edge[l] = t_edge + gp + 2;
      end
      m_p1[l]  = pop && !head;
      m_p5[l]  = pop && head;
      m_jam[l] = ev1 && ev5;
      m_ovf[l] = 1'b0;
      if (ev1 != ev5) begin
        if (q.size() < QD) q.push_back(ev5);
        else               m_ovf[l] = 1'b1;
      end
      debd1[l] = deb1[l];
      debd5[l] = deb5[l];
      if (settled(h1[l], deb1[l], dcy)) deb1[l] = ~deb1[l];
      if (settled(h5[l], deb5[l], dcy)) deb5[l] = ~deb5[l];
      h1[l] = {h1[l][14:0], c1};
      h5[l] = {h5[l][14:0], c5};
      m_busy[l]    = (q.size() > 0) || (t_edge < ready_edge[l] - 1);
      m_pending[l] = q.size();
    end
    if (l == 0) q0 = q; else q1 = q;
  endfunction

  function automatic logic [7:0] exp_vec(input int l);
    return {m_p1[l], m_p5[l], m_jam[l], m_ovf[l], m_busy[l], 3'(m_pending[l])};
  endfunction

  function automatic logic [7:0] obs_vec(input int l);
    if (l == 0) return {P1, P5, jam, ovf, busy, pending};
    return {s_P1, s_P5, s_jam, s_ovf, s_busy, s_pending};
  endfunction

  // Drive both lanes for one cycle; returns just after the following negedge.
  task automatic tick(input bit a1, input bit a5, input bit b1, input bit b5, input bit rn);
    coin1_raw = a1; coin5_raw = a5; s_coin1 = b1; s_coin5 = b5; rst_n = rn;
    t_edge++;
    model_step(0, a1, a5, rn);
    model_step(1, b1, b5, rn);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(i[0], ~i[0], ~i[0], i[0], 0);
      checks++;
      if (obs_vec(0) !== 8'h00 || obs_vec(1) !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b/%b want 00000000", i, obs_vec(0), obs_vec(1));
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0, 1);
      checks++;
      if (obs_vec(0) !== exp_vec(0) || P1 !== 1'b0 || P5 !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b want %b", i, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_single_coin();
    int p5_at = -1, p5_cnt = 0, p1_cnt = 0, pend1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, i < 12, 0, 0, 1);
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL single_coin cycle %0d: got %b want %b", i, obs_vec(0), exp_vec(0));
      end
      if (P5) begin p5_cnt++; p5_at = i; end
      if (P1) p1_cnt++;
      if (pending == 3'd1) pend1++;
    end
    checks++;
    if (p5_cnt !== 1 || p5_at !== 7) begin
      errors++;
      $display("FAIL single_coin_latency: got %0d pulses at offset %0d, want 1 at 7", p5_cnt, p5_at);
    end
    checks++;
    if (p1_cnt !== 0 || pend1 !== 1) begin
      errors++;
      $display("FAIL single_coin_side: got P1 count %0d pending1 cycles %0d, want 0 and 1", p1_cnt, pend1);
    end
  endtask

  task automatic test_bounce();
    int p1_cnt = 0, p1_at = -1;
    for (int i = 0; i < 70; i++) begin
      tick((i < 20) ? (i % 2 == 0) : (i < 45), 0, 0, 0, 1);
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %b want %b", i, obs_vec(0), exp_vec(0));
      end
      if (P1) begin p1_cnt++; p1_at = i; end
    end
    // First stable high sample is cycle 20; pulse follows 7 edges later.
    checks++;
    if (p1_cnt !== 1 || p1_at !== 27) begin
      errors++;
      $display("FAIL bounce_single: got %0d pulses at %0d, want 1 at 27", p1_cnt, p1_at);
    end
  endtask

  task automatic test_burst();
    int p1_cnt = 0, ovf_cnt = 0, last = -1;
    for (int i = 0; i < 110; i++) begin
      tick((i < 60) && ((i % 12) < 6), 0, 0, 0, 1);
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL burst cycle %0d: got %b want %b", i, obs_vec(0), exp_vec(0));
      end
      if (ovf) ovf_cnt++;
      if (P1) begin
        checks++;
        if (last >= 0 && (i - last - 1) < L0_GAP) begin
          errors++;
          $display("FAIL burst_spacing: got %0d low cycles, want >= %0d", i - last - 1, L0_GAP);
        end
        last = i;
        p1_cnt++;
      end
    end
    checks++;
    if (p1_cnt !== 5 - ovf_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_count: got %0d pulses busy=%b, want %0d busy=0", p1_cnt, busy, 5 - ovf_cnt);
    end
  endtask

  task automatic test_jam();
    int jam_cnt = 0, p_cnt = 0, pend_max = 0;
    for (int i = 0; i < 35; i++) begin
      tick(i < 10, i < 10, 0, 0, 1);
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL jam cycle %0d: got %b want %b", i, obs_vec(0), exp_vec(0));
      end
      if (jam) jam_cnt++;
      if (P1 || P5) p_cnt++;
      if (int'(pending) > pend_max) pend_max = int'(pending);
    end
    checks++;
    if (jam_cnt !== 1 || p_cnt !== 0 || pend_max !== 0) begin
      errors++;
      $display("FAIL jam_summary: got jam=%0d pulses=%0d pending_max=%0d, want 1 0 0", jam_cnt, p_cnt, pend_max);
    end
  endtask

  task automatic test_random();
    int rem1 = 0, rem5 = 0, last = -1;
    bit lv1 = 0, lv5 = 0, rn;
    for (int i = 0; i < 1500; i++) begin
      if (rem1 <= 0 && rem5 <= 0 && !lv1 && !lv5 && $urandom_range(0, 3) == 0) begin
        lv1 = 1; lv5 = 1; rem1 = $urandom_range(4, 10); rem5 = rem1;
      end
      if (rem1 <= 0) begin lv1 = ~lv1; rem1 = $urandom_range(1, 12); end
      if (rem5 <= 0) begin lv5 = ~lv5; rem5 = $urandom_range(1, 12); end
      rem1--; rem5--;
      rn = ($urandom_range(0, 499) != 0);
      tick(lv1, lv5, 0, 0, rn);
      if (!rn) last = -1;
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", i, obs_vec(0), exp_vec(0));
      end
      if (P1 || P5) begin
        checks++;
        if ((P1 && P5) || (last >= 0 && (i - last - 1) < L0_GAP)) begin
          errors++;
          $display("FAIL random_spacing cycle %0d: got P1=%b P5=%b gap %0d, want exclusive gap >= %0d",
                   i, P1, P5, i - last - 1, L0_GAP);
        end
        last = i;
      end
    end
  endtask

  task automatic test_overflow();
    int ovf_cnt = 0, p_cnt = 0, both = 0;
    for (int i = 0; i < 140; i++) begin
      tick(0, 0, (i < 24) && (i % 2 == 0), (i < 24) && (i % 2 == 1), 1);
      checks++;
      if (obs_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL overflow cycle %0d: got %b want %b", i, obs_vec(1), exp_vec(1));
      end
      if (s_ovf) ovf_cnt++;
      if (s_P1 || s_P5) p_cnt++;
      if (s_P1 && s_P5) both++;
    end
    // 24 alternating single-cycle events; every one is either emitted or dropped.
    checks++;
    if (ovf_cnt == 0 || p_cnt !== 24 - ovf_cnt || both !== 0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_summary: got ovf=%0d pulses=%0d both=%0d busy=%b, want ovf>0 pulses=24-ovf both=0 busy=0",
               ovf_cnt, p_cnt, both, s_busy);
    end
  endtask

  task automatic test_reset_mid_queue();
    bit found = 0;
    int late = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(0, 0, (i < 8) && (i % 2 == 0), (i < 8) && (i % 2 == 1), 1);
      checks++;
      if (obs_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL midq_fill cycle %0d: got %b want %b", i, obs_vec(1), exp_vec(1));
      end
      if ((s_P1 || s_P5) && s_pending >= 3'd3) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midq_emit: got no pulse with 3 queued within 60 cycles, want one");
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (obs_vec(1) !== 8'h00) begin
      errors++;
      $display("FAIL midq_reset: got %b want 00000000", obs_vec(1));
    end
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 0, 0, 1);
      if (s_P1 || s_P5 || s_pending != 3'd0) late++;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL midq_after: got %0d active cycles after reset, want 0", late);
    end
  endtask

  task automatic test_random_stress();
    bit rn;
    for (int i = 0; i < 800; i++) begin
      rn = ($urandom_range(0, 299) != 0);
      tick(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rn);
      checks++;
      if (obs_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL random_stress cycle %0d: got %b want %b", i, obs_vec(1), exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_coin();
    test_bounce();
    test_burst();
    test_jam();
    test_random();
    pulse_reset();
    test_overflow();
    test_reset_mid_queue();
    test_random_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
